// File: rtl/mem_wb_stage_if.sv
// MEM -> WB bundle: instruction fields from the MEM stage plus the register-file
// write request and status coming back out of the MEM/WB register.
interface mem_wb_stage_if #(
    parameter int CNT_W = 32
);
    logic             in_mem_valid;
    logic             out_mem_ready;
    logic             in_stall;
    logic             in_flush;
    logic             in_rd_wena;
    logic [4:0]       in_rd_addr;
    logic [1:0]       in_wb_sel;
    logic [31:0]      in_alu_result;
    logic [31:0]      in_load_data;
    logic [1:0]       in_addr_low;
    logic [2:0]       in_load_type;
    logic [31:0]      in_link_pc;
    logic [31:0]      in_hilo_data;
    logic             out_rd_wena;
    logic [4:0]       out_rd_addr;
    logic [31:0]      out_rd_data;
    logic             out_wb_valid;
    logic             out_misalign;
    logic [CNT_W-1:0] out_retired_count;

    modport slave (
        input  in_mem_valid, in_stall, in_flush, in_rd_wena, in_rd_addr, in_wb_sel,
               in_alu_result, in_load_data, in_addr_low, in_load_type, in_link_pc,
               in_hilo_data,
        output out_mem_ready, out_rd_wena, out_rd_addr, out_rd_data, out_wb_valid,
               out_misalign, out_retired_count
    );

    modport master (
        output in_mem_valid, in_stall, in_flush, in_rd_wena, in_rd_addr, in_wb_sel,
               in_alu_result, in_load_data, in_addr_low, in_load_type, in_link_pc,
               in_hilo_data,
        input  out_mem_ready, out_rd_wena, out_rd_addr, out_rd_data, out_wb_valid,
               out_misalign, out_retired_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback formatter: selects the writeback source,
// aligns/extends load data, suppresses misaligned loads and counts retirements.
module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic          in_clk,
    input  logic          in_rst_n,
    mem_wb_stage_if.slave bus
);
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    // Little-endian byte/halfword extraction; unknown load types behave as LW.
    function automatic logic [31:0] format_load(input logic [31:0] data,
                                                input logic [1:0]  addr_low,
                                                input logic [2:0]  load_type);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        byte_v = data[{addr_low, 3'b000} +: 8];
        half_v = data[{addr_low[1], 4'b0000} +: 16];
        case (load_type)
            LT_LB:   res_v = {{24{byte_v[7]}}, byte_v};
            LT_LBU:  res_v = {24'h00_0000, byte_v};
            LT_LH:   res_v = {{16{half_v[15]}}, half_v};
            LT_LHU:  res_v = {16'h0000, half_v};
            default: res_v = data;
        endcase
        return res_v;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] wb_sel,
                                           input logic [1:0] addr_low,
                                           input logic [2:0] load_type);
        logic mis_v;
        if (wb_sel != 2'b01) begin
            mis_v = 1'b0;
        end else begin
            case (load_type)
                LT_LB, LT_LBU: mis_v = 1'b0;
                LT_LH, LT_LHU: mis_v = addr_low[0];
                default:       mis_v = (addr_low != 2'b00);
            endcase
        end
        return mis_v;
    endfunction

    logic [31:0]      wb_data_s;
    logic             misalign_s;
    logic             wena_s;
    logic             valid_r;
    logic             fresh_r;
    logic             rd_wena_r;
    logic             misalign_r;
    logic [4:0]       rd_addr_r;
    logic [31:0]      rd_data_r;
    logic [CNT_W-1:0] cnt_r;

    // Writeback source select and write-enable qualification ahead of the register.
    always_comb begin
        wb_data_s = bus.in_alu_result;
        case (bus.in_wb_sel)
            2'b00:   wb_data_s = bus.in_alu_result;
            2'b01:   wb_data_s = format_load(bus.in_load_data, bus.in_addr_low, bus.in_load_type);
            2'b10:   wb_data_s = bus.in_link_pc;
            2'b11:   wb_data_s = bus.in_hilo_data;
            default: wb_data_s = bus.in_alu_result;
        endcase
        misalign_s = is_misaligned(bus.in_wb_sel, bus.in_addr_low, bus.in_load_type);
        wena_s     = bus.in_rd_wena & ~misalign_s & (bus.in_rd_addr != 5'd0);
    end

    // WB entry register: flush beats stall; a held entry only strobes in its fresh cycle.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            valid_r    <= 1'b0;
            fresh_r    <= 1'b0;
            rd_wena_r  <= 1'b0;
            misalign_r <= 1'b0;
            rd_addr_r  <= 5'd0;
            rd_data_r  <= 32'h0000_0000;
        end else if (bus.in_flush || (!bus.in_stall && !bus.in_mem_valid)) begin
            valid_r    <= 1'b0;
            fresh_r    <= 1'b0;
            rd_wena_r  <= 1'b0;
            misalign_r <= 1'b0;
            rd_addr_r  <= 5'd0;
            rd_data_r  <= 32'h0000_0000;
        end else if (bus.in_stall) begin
            valid_r    <= valid_r;
            fresh_r    <= 1'b0;
            rd_wena_r  <= 1'b0;
            misalign_r <= 1'b0;
            rd_addr_r  <= rd_addr_r;
            rd_data_r  <= rd_data_r;
        end else begin
            valid_r    <= 1'b1;
            fresh_r    <= 1'b1;
            rd_wena_r  <= wena_s;
            misalign_r <= misalign_s;
            rd_addr_r  <= bus.in_rd_addr;
            rd_data_r  <= wb_data_s;
        end
    end

    // Retired-instruction counter, bumped once per valid non-faulting entry.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (fresh_r && valid_r && !misalign_r) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.out_mem_ready     = ~bus.in_stall;
    assign bus.out_rd_wena       = rd_wena_r;
    assign bus.out_rd_addr       = rd_addr_r;
    assign bus.out_rd_data       = rd_data_r;
    assign bus.out_wb_valid      = valid_r;
    assign bus.out_misalign      = misalign_r;
    assign bus.out_retired_count = cnt_r;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage: the driver queues hand-computed expected
// WB outputs per cycle, a monitor pops and compares them on the falling edge.
module tb_mem_wb_stage;
    localparam int CNT_W = 8;

    typedef struct {
        int          id;
        logic        wena;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        valid;
        logic        mis;
        logic [7:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   step = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.CNT_W(CNT_W)) bus ();

    mem_wb_stage #(.CNT_W(CNT_W)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, id, got, exp);
        end
    endtask

    // One clock: present inputs, then queue the outputs expected after the edge.
    task automatic cyc(input logic rn, input logic v, input logic st, input logic fl,
                       input logic we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [2:0] lt, input logic [1:0] al,
                       input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                       input logic ev, input logic em, input logic [7:0] ec);
        exp_t e;
        rst_n             = rn;
        bus.in_mem_valid  = v;
        bus.in_stall      = st;
        bus.in_flush      = fl;
        bus.in_rd_wena    = we;
        bus.in_rd_addr    = rd;
        bus.in_wb_sel     = sel;
        bus.in_alu_result = alu;
        bus.in_load_type  = lt;
        bus.in_addr_low   = al;
        @(posedge clk);
        #1;
        e.id = step; e.wena = ew; e.addr = ea; e.data = ed;
        e.valid = ev; e.mis = em; e.cnt = ec;
        sb_q.push_back(e);
        step++;
    endtask

    // Monitor: compare the WB outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("rd_wena",  mon_e.id, {31'd0, bus.out_rd_wena},  {31'd0, mon_e.wena});
            chk("rd_addr",  mon_e.id, {27'd0, bus.out_rd_addr},  {27'd0, mon_e.addr});
            chk("rd_data",  mon_e.id, bus.out_rd_data,           mon_e.data);
            chk("wb_valid", mon_e.id, {31'd0, bus.out_wb_valid}, {31'd0, mon_e.valid});
            chk("misalign", mon_e.id, {31'd0, bus.out_misalign}, {31'd0, mon_e.mis});
            chk("retired",  mon_e.id, {24'd0, bus.out_retired_count}, {24'd0, mon_e.cnt});
            chk("mem_ready", mon_e.id, {31'd0, bus.out_mem_ready}, {31'd0, ~bus.in_stall});
        end
    end

    initial begin
        bus.in_mem_valid  = 1'b0;
        bus.in_stall      = 1'b0;
        bus.in_flush      = 1'b0;
        bus.in_rd_wena    = 1'b0;
        bus.in_rd_addr    = 5'd0;
        bus.in_wb_sel     = 2'b00;
        bus.in_alu_result = 32'h0000_0000;
        bus.in_load_data  = 32'h80FF_7F01;
        bus.in_addr_low   = 2'b00;
        bus.in_load_type  = 3'b000;
        bus.in_link_pc    = 32'h0040_0108;
        bus.in_hilo_data  = 32'hCAFE_F00D;

        // rn  v    st   fl   we   rd     sel    alu            lt    al      ew   ea     ed             ev   em   cnt
        cyc(1'b0,1'b1,1'b0,1'b0,1'b1,5'd8, 2'b00,32'h1234_5678,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0000,1'b0,1'b0,8'd0);
        cyc(1'b0,1'b1,1'b1,1'b0,1'b1,5'd8, 2'b00,32'h1234_5678,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0000,1'b0,1'b0,8'd0);
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd8, 2'b00,32'h1234_5678,3'd0,2'd0,  1'b1,5'd8, 32'h1234_5678,1'b1,1'b0,8'd0);
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd3, 2'b01,32'h0000_0000,3'd1,2'd3,  1'b1,5'd3, 32'hFFFF_FF80,1'b1,1'b0,8'd1);
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd4, 2'b01,32'h0000_0000,3'd2,2'd3,  1'b1,5'd4, 32'h0000_0080,1'b1,1'b0,8'd2);
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd6, 2'b01,32'h0000_0000,3'd3,2'd2,  1'b1,5'd6, 32'hFFFF_80FF,1'b1,1'b0,8'd3);
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd7, 2'b01,32'h0000_0000,3'd4,2'd0,  1'b1,5'd7, 32'h0000_7F01,1'b1,1'b0,8'd4);
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd10,2'b01,32'h0000_0000,3'd1,2'd1,  1'b1,5'd10,32'h0000_007F,1'b1,1'b0,8'd5);
        // misaligned LW: pulse, no write, not retired
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd5, 2'b01,32'h0000_0000,3'd0,2'd1,  1'b0,5'd5, 32'h80FF_7F01,1'b1,1'b1,8'd6);
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd31,2'b10,32'h0000_0000,3'd0,2'd0,  1'b1,5'd31,32'h0040_0108,1'b1,1'b0,8'd6);
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd2, 2'b11,32'h0000_0000,3'd0,2'd0,  1'b1,5'd2, 32'hCAFE_F00D,1'b1,1'b0,8'd7);
        // capture rd=9 then stall three cycles
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd9, 2'b00,32'hA5A5_0009,3'd0,2'd0,  1'b1,5'd9, 32'hA5A5_0009,1'b1,1'b0,8'd8);
        cyc(1'b1,1'b1,1'b1,1'b0,1'b1,5'd12,2'b00,32'h1111_1111,3'd0,2'd0,  1'b0,5'd9, 32'hA5A5_0009,1'b1,1'b0,8'd9);
        cyc(1'b1,1'b1,1'b1,1'b0,1'b1,5'd12,2'b00,32'h1111_1111,3'd0,2'd0,  1'b0,5'd9, 32'hA5A5_0009,1'b1,1'b0,8'd9);
        cyc(1'b1,1'b1,1'b1,1'b0,1'b1,5'd12,2'b00,32'h1111_1111,3'd0,2'd0,  1'b0,5'd9, 32'hA5A5_0009,1'b1,1'b0,8'd9);
        cyc(1'b1,1'b0,1'b0,1'b0,1'b1,5'd12,2'b00,32'h1111_1111,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0000,1'b0,1'b0,8'd9);
        // flush with stall and valid input -> bubble
        cyc(1'b1,1'b1,1'b1,1'b1,1'b1,5'd11,2'b00,32'h2222_2222,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0000,1'b0,1'b0,8'd9);
        // rd=0 ALU op: no write but retired
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd0, 2'b00,32'h0000_0055,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0055,1'b1,1'b0,8'd9);
        cyc(1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 2'b00,32'h0000_0000,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0000,1'b0,1'b0,8'd10);
        cyc(1'b1,1'b1,1'b0,1'b0,1'b0,5'd13,2'b00,32'h0000_0077,3'd0,2'd0,  1'b0,5'd13,32'h0000_0077,1'b1,1'b0,8'd10);
        cyc(1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 2'b00,32'h0000_0000,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0000,1'b0,1'b0,8'd11);
        // misaligned LHU then stalled: pulse only once
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd14,2'b01,32'h0000_0000,3'd4,2'd3,  1'b0,5'd14,32'h0000_80FF,1'b1,1'b1,8'd11);
        cyc(1'b1,1'b1,1'b1,1'b0,1'b1,5'd14,2'b01,32'h0000_0000,3'd4,2'd3,  1'b0,5'd14,32'h0000_80FF,1'b1,1'b0,8'd11);
        cyc(1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 2'b00,32'h0000_0000,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0000,1'b0,1'b0,8'd11);
        // reserved load type behaves as LW
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd15,2'b01,32'h0000_0000,3'd7,2'd0,  1'b1,5'd15,32'h80FF_7F01,1'b1,1'b0,8'd11);
        cyc(1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 2'b00,32'h0000_0000,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0000,1'b0,1'b0,8'd12);

        // back-to-back retires walk the 8-bit counter through 255 -> 0
        for (int i = 0; i < 250; i++) begin
            cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd1,2'b00,32'h1000_0000 + i,3'd0,2'd0,
                1'b1,5'd1,32'h1000_0000 + i,1'b1,1'b0,8'(12 + i));
        end

        // reset while stalled discards the held entry
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd20,2'b00,32'hDEAD_BEEF,3'd0,2'd0,  1'b1,5'd20,32'hDEAD_BEEF,1'b1,1'b0,8'd6);
        cyc(1'b1,1'b1,1'b1,1'b0,1'b1,5'd20,2'b00,32'hDEAD_BEEF,3'd0,2'd0,  1'b0,5'd20,32'hDEAD_BEEF,1'b1,1'b0,8'd7);
        cyc(1'b0,1'b1,1'b1,1'b0,1'b1,5'd20,2'b00,32'hDEAD_BEEF,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0000,1'b0,1'b0,8'd0);
        cyc(1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 2'b00,32'h0000_0000,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0000,1'b0,1'b0,8'd0);
        cyc(1'b1,1'b1,1'b0,1'b0,1'b1,5'd21,2'b00,32'h0000_0001,3'd0,2'd0,  1'b1,5'd21,32'h0000_0001,1'b1,1'b0,8'd0);
        cyc(1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 2'b00,32'h0000_0000,3'd0,2'd0,  1'b0,5'd0, 32'h0000_0000,1'b0,1'b0,8'd1);

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback formatter of the 5-stage MIPS pipeline; sits directly upstream of the register file and drives its single write port (`rd_wena/addr/data`). Captures one instruction per cycle from the MEM stage and selects the writeback source (ALU, load, link, HI/LO). Aligns and extends load data, suppresses faulting writes and counts retired instructions. Output is fully registered, so the register file sees a clean, stable write request for one full cycle.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter
- `in_clk`  in  1  clock; all state updates on rising edge
- `in_rst_n`  in  1  reset, synchronous, active-low
- `in_mem_valid`  in  1  MEM stage presents an instruction this cycle
- `out_mem_ready`  out  1  stage accepts; combinational `= ~in_stall`
- `in_stall`  in  1  hold current WB entry (debug halt / external freeze)
- `in_flush`  in  1  discard the incoming MEM entry
- `in_rd_wena`  in  1  instruction writes a GPR
- `in_rd_addr`  in  5  destination GPR
- `in_wb_sel`  in  2  00 ALU, 01 load, 10 link, 11 HI/LO
- `in_alu_result`  in  32  ALU result
- `in_load_data`  in  32  raw aligned word from data memory
- `in_addr_low`  in  2  byte offset `addr[1:0]` of load
- `in_load_type`  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others treated as LW
- `in_link_pc`  in  32  PC+8 for JAL/JALR/BGEZAL
- `in_hilo_data`  in  32  MFHI/MFLO value
- `out_rd_wena`  out  1  write strobe to register file
- `out_rd_addr`  out  5  write address
- `out_rd_data`  out  32  write data
- `out_wb_valid`  out  1  WB register holds a live instruction
- `out_misalign`  out  1  one-cycle pulse: load address misaligned, write suppressed
- `out_retired_count`  out  `CNT_W`  instructions retired since reset

## Operation
- Capture condition: rising edge with `in_rst_n=1`, `in_stall=0`, `in_mem_valid=1`, `in_flush=0` -> entry loaded, `fresh` flag set.
- Bubble condition: `in_stall=0` and (`in_mem_valid=0` or `in_flush=1`) -> register loads bubble (`out_wb_valid=0`, all strobes 0).
- `in_flush` has priority over `in_stall`: flush+stall in same cycle loads a bubble.
- Stall: `in_stall=1` (no flush) -> entry held; `fresh` cleared after its first cycle, so `out_rd_wena`, `out_misalign` and the counter increment occur exactly once per entry; `out_rd_addr/data/out_wb_valid` remain stable.
- Data select (combinational, before the register): ALU -> `in_alu_result`; link -> `in_link_pc`; HI/LO -> `in_hilo_data`; load -> formatted load.
- Load formatting, little-endian: LB/LBU byte = `data[8*addr_low +: 8]`, sign/zero-extend to 32; LH/LHU half = `data[16*addr_low[1] +: 16]`, sign/zero-extend; LW full word.
- Misalign: `wb_sel=01` and (LH/LHU with `addr_low[0]=1` or LW with `addr_low!=0`) -> `out_rd_wena=0`, `out_misalign=1` for the fresh cycle, instruction not counted as retired.
- `out_rd_wena = fresh & valid & in_rd_wena_q & ~misalign_q & (rd_addr_q != 0)`.
- Retire: counter +1 in the fresh cycle of each valid, non-misaligned entry (including `rd_addr=0` and non-writing instructions); wraps all-ones -> 0.

## Timing
- Latency: MEM inputs at edge N -> `out_rd_*` valid from N until N+1; register file commits at edge N+1.
- `out_mem_ready` is combinational on `in_stall` only; no other combinational input-to-output paths.
- Counter value updated at the edge following the fresh cycle.
- Reset (`in_rst_n=0` at an edge): `out_rd_wena=0`, `out_rd_addr=0`, `out_rd_data=0`, `out_wb_valid=0`, `out_misalign=0`, `out_retired_count=0`, `fresh=0`; reset overrides stall/flush/valid; an entry held mid-stall is discarded without write or count.
- First capture possible at the first edge with `in_rst_n=1`.

## Test plan
- Reset then ALU op `rd=8`, result 0x1234_5678 -> next cycle `out_rd_wena=1`, addr 8, data 0x1234_5678; count 0 -> 1.
- LB, data 0x80FF_7F01, `addr_low=3` -> data 0xFFFF_FF80; LBU same -> 0x0000_0080; LH `addr_low=2` -> 0xFFFF_80FF.
- LW with `addr_low=1`, `rd=5` -> `out_misalign` one-cycle pulse, `out_rd_wena=0`, count unchanged.
- Capture `rd=9` then assert `in_stall` 3 cycles -> `out_rd_wena` high 1 cycle only, outputs stable, count +1 once.
- `in_flush=1` with `in_stall=1` and valid input -> bubble, no write, count unchanged; `rd=0` ALU op -> no write, count +1.
- Preload counter to 0xFFFF_FFFF via 2^32-1 retires (or force) then retire one -> 0; assert `in_rst_n=0` mid-stall -> all outputs 0 next cycle.
